conv_mux_sequencer: RTL and testbench

- Registered, parametrised successor of the memory/convolver routing crossbar for the 2D-convolution datapath.
- Sits between the N convolvers and the M = N+K-1 line memories.
- Kernel height K is generic, and it owns the rotating substate counter instead of taking it as an input.
- Adds per-memory write enables, a valid pipeline, a readout port and a wrap indication.

---
 rtl/conv_mux_pkg.sv | 52 +++++
 rtl/conv_mux_route.sv | 66 ++++++
 rtl/conv_mux_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_conv_mux_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mux_pkg.sv
// Shared definitions for the convolver/memory routing sequencer: mode encodings
// and the constant helpers used to size the memory count, substate period and buses.
package conv_mux_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_CONV = 2'b01,
    MODE_READ = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int gcd(input int x, input int y);
    int a;
    int b;
    int t;
    a = x;
    b = y;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int calc_m(input int n, input int k);
    return n + k - 1;
  endfunction

  function automatic int calc_sub(input int n, input int m);
    return m / gcd(n, m);
  endfunction

  // Bus width for an index in [0, value), never narrower than one bit.
  function automatic int width_of(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

  // The read select is one value wider than the memory range so that an
  // out-of-range index can be presented and answered with zero.
  function automatic int sel_width(input int m);
    return clog2(m + 1);
  endfunction

endpackage

// File: rtl/conv_mux_route.sv
// Combinational routing between line memories and convolvers: given the mode
// and the rotating base address it produces the next value of every output bus.
module conv_mux_route
  import conv_mux_pkg::*;
#(
  parameter int N           = 2,
  parameter int K           = 3,
  parameter int BITS_IMAGEN = 8,
  parameter int BITS_DATA   = 13,
  parameter int M           = N + K - 1,
  parameter int BASE_W      = 2,
  parameter int SEL_W       = 3
) (
  input  mode_e                        mode,
  input  logic [BASE_W-1:0]            base,
  input  logic                         valid,
  input  logic [BITS_IMAGEN-1:0]       data_in,
  input  logic [N*BITS_DATA-1:0]       data_conv,
  input  logic [M*BITS_DATA-1:0]       mem_data,
  input  logic [SEL_W-1:0]             mem_select,
  output logic [N*K*BITS_IMAGEN-1:0]   conv_nxt,
  output logic [M*BITS_DATA-1:0]       mem_nxt,
  output logic [M-1:0]                 we_nxt,
  output logic [BITS_DATA-1:0]         data_nxt
);

  always_comb begin
    int base_i;
    int idx;
    base_i   = int'(base);
    idx      = 0;
    conv_nxt = '0;
    mem_nxt  = '0;
    we_nxt   = '0;
    data_nxt = '0;
    case (mode)
      MODE_LOAD: begin
        for (int j = 0; j < M; j++) begin
          mem_nxt[j*BITS_DATA +: BITS_DATA] = BITS_DATA'(data_in);
          we_nxt[j] = valid;
        end
      end
      MODE_CONV: begin
        // Convolver i reads a K-line window starting at base+i and writes back
        // to the line at the bottom of that window.
        for (int i = 0; i < N; i++) begin
          for (int k = 0; k < K; k++) begin
            idx = (base_i + i + k) % M;
            conv_nxt[(i*K+k)*BITS_IMAGEN +: BITS_IMAGEN] =
              mem_data[idx*BITS_DATA +: BITS_IMAGEN];
          end
          idx = (base_i + i) % M;
          mem_nxt[idx*BITS_DATA +: BITS_DATA] = data_conv[i*BITS_DATA +: BITS_DATA];
          we_nxt[idx] = valid;
        end
      end
      MODE_READ: begin
        if (int'(mem_select) < M)
          data_nxt = mem_data[int'(mem_select)*BITS_DATA +: BITS_DATA];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/conv_mux_sequencer.sv
// Registered memory/convolver crossbar with its own rotating substate counter.
// Define CONV_MUX_PIPE2_EN to add a second output register stage (latency 2).
module conv_mux_sequencer
  import conv_mux_pkg::*;
#(
  parameter int N           = 2,
  parameter int K           = 3,
  parameter int BITS_IMAGEN = 8,
  parameter int BITS_DATA   = 13,
  localparam int M          = calc_m(N, K),
  localparam int SUB        = calc_sub(N, M),
  localparam int SUB_W      = width_of(SUB),
  localparam int BASE_W     = width_of(M),
  localparam int SEL_W      = sel_width(M)
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [1:0]                   i_mode,
  input  logic                         i_valid,
  input  logic                         i_advance,
  input  logic                         i_clearSub,
  input  logic [N*BITS_DATA-1:0]       i_DataConv,
  input  logic [M*BITS_DATA-1:0]       i_MemData,
  input  logic [BITS_IMAGEN-1:0]       i_Data,
  input  logic [SEL_W-1:0]             i_memSelect,
  output logic [N*K*BITS_IMAGEN-1:0]   o_DataConv,
  output logic [M*BITS_DATA-1:0]       o_MemData,
  output logic [M-1:0]                 o_memWe,
  output logic [BITS_DATA-1:0]         o_Data,
  output logic                         o_valid,
  output logic [SUB_W-1:0]             o_substate,
  output logic                         o_wrap
);

  localparam int CONV_W = N * K * BITS_IMAGEN;
  localparam int MEM_W  = M * BITS_DATA;

  mode_e               mode;
  logic                hold;
  logic [BASE_W-1:0]   base;

  logic [CONV_W-1:0]   conv_nxt, conv_d, conv_q;
  logic [MEM_W-1:0]    mem_nxt, mem_d, mem_q;
  logic [M-1:0]        we_nxt, we_d, we_q;
  logic [BITS_DATA-1:0] data_nxt, data_d, data_q;
  logic                valid_d, valid_q;
  logic [SUB_W-1:0]    sub_d, sub_q;
  logic                wrap_d, wrap_q;

  assign mode = mode_e'(i_mode);
  assign hold = (mode == MODE_HOLD);
  // Multiply in full integer width before reducing so the product never aliases.
  assign base = BASE_W'((int'(sub_q) * N) % M);

  conv_mux_route #(
    .N          (N),
    .K          (K),
    .BITS_IMAGEN(BITS_IMAGEN),
    .BITS_DATA  (BITS_DATA),
    .M          (M),
    .BASE_W     (BASE_W),
    .SEL_W      (SEL_W)
  ) u_route (
    .mode      (mode),
    .base      (base),
    .valid     (i_valid),
    .data_in   (i_Data),
    .data_conv (i_DataConv),
    .mem_data  (i_MemData),
    .mem_select(i_memSelect),
    .conv_nxt  (conv_nxt),
    .mem_nxt   (mem_nxt),
    .we_nxt    (we_nxt),
    .data_nxt  (data_nxt)
  );

  always_comb begin
    sub_d  = sub_q;
    wrap_d = 1'b0;
    if (i_clearSub) begin
      sub_d = '0;
    end else if (mode == MODE_CONV && i_advance) begin
      if (sub_q == SUB_W'(SUB - 1)) begin
        sub_d  = '0;
        wrap_d = 1'b1;
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

`ifdef CONV_MUX_PIPE2_EN
  logic                 hold1_d, hold1_q;
  logic [CONV_W-1:0]    conv2_d, conv2_q;
  logic [MEM_W-1:0]     mem2_d, mem2_q;
  logic [M-1:0]         we2_d, we2_q;
  logic [BITS_DATA-1:0] data2_d, data2_q;
  logic                 valid2_d, valid2_q;
  logic [SUB_W-1:0]     sub2_d, sub2_q;
  logic                 wrap2_d, wrap2_q;

  // Stage 1 always captures; the HOLD decision travels with the data and
  // freezes stage 2 so the frozen word is the last one before the HOLD.
  always_comb begin
    conv_d   = conv_nxt;
    mem_d    = mem_nxt;
    data_d   = data_nxt;
    we_d     = we_nxt;
    valid_d  = i_valid && !hold;
    hold1_d  = hold;
    conv2_d  = hold1_q ? conv2_q : conv_q;
    mem2_d   = hold1_q ? mem2_q  : mem_q;
    data2_d  = hold1_q ? data2_q : data_q;
    we2_d    = we_q;
    valid2_d = valid_q;
    sub2_d   = sub_q;
    wrap2_d  = wrap_q;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      hold1_q  <= 1'b0;
      conv2_q  <= '0;
      mem2_q   <= '0;
      we2_q    <= '0;
      data2_q  <= '0;
      valid2_q <= 1'b0;
      sub2_q   <= '0;
      wrap2_q  <= 1'b0;
    end else begin
      hold1_q  <= hold1_d;
      conv2_q  <= conv2_d;
      mem2_q   <= mem2_d;
      we2_q    <= we2_d;
      data2_q  <= data2_d;
      valid2_q <= valid2_d;
      sub2_q   <= sub2_d;
      wrap2_q  <= wrap2_d;
    end
  end

  assign o_DataConv = conv2_q;
  assign o_MemData  = mem2_q;
  assign o_memWe    = we2_q;
  assign o_Data     = data2_q;
  assign o_valid    = valid2_q;
  assign o_substate = sub2_q;
  assign o_wrap     = wrap2_q;
`else
  always_comb begin
    conv_d  = hold ? conv_q : conv_nxt;
    mem_d   = hold ? mem_q  : mem_nxt;
    data_d  = hold ? data_q : data_nxt;
    we_d    = we_nxt;
    valid_d = i_valid && !hold;
  end

  assign o_DataConv = conv_q;
  assign o_MemData  = mem_q;
  assign o_memWe    = we_q;
  assign o_Data     = data_q;
  assign o_valid    = valid_q;
  assign o_substate = sub_q;
  assign o_wrap     = wrap_q;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      conv_q  <= '0;
      mem_q   <= '0;
      we_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sub_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      conv_q  <= conv_d;
      mem_q   <= mem_d;
      we_q    <= we_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sub_q   <= sub_d;
      wrap_q  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_conv_mux_sequencer.sv
// Bench for conv_mux_sequencer (default single-stage build, N=2 K=3 M=4 SUB=2):
// directed vector table, reset/HOLD sequences, then random traffic against a model.
module tb_conv_mux_sequencer;

  localparam int N   = 2;
  localparam int K   = 3;
  localparam int BI  = 8;
  localparam int BD  = 13;
  localparam int M   = 4;
  localparam int SUB = 2;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] CONV = 2'b01;
  localparam logic [1:0] READ = 2'b10;
  localparam logic [1:0] HOLD = 2'b11;

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b0;
  logic [1:0]        i_mode = LOAD;
  logic              i_valid = 1'b0;
  logic              i_advance = 1'b0;
  logic              i_clearSub = 1'b0;
  logic [N*BD-1:0]   i_DataConv = '0;
  logic [M*BD-1:0]   i_MemData = '0;
  logic [BI-1:0]     i_Data = '0;
  logic [2:0]        i_memSelect = '0;
  logic [N*K*BI-1:0] o_DataConv;
  logic [M*BD-1:0]   o_MemData;
  logic [M-1:0]      o_memWe;
  logic [BD-1:0]     o_Data;
  logic              o_valid;
  logic [0:0]        o_substate;
  logic              o_wrap;

  int checks = 0;
  int errors = 0;

  conv_mux_sequencer dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_mode     (i_mode),
    .i_valid    (i_valid),
    .i_advance  (i_advance),
    .i_clearSub (i_clearSub),
    .i_DataConv (i_DataConv),
    .i_MemData  (i_MemData),
    .i_Data     (i_Data),
    .i_memSelect(i_memSelect),
    .o_DataConv (o_DataConv),
    .o_MemData  (o_MemData),
    .o_memWe    (o_memWe),
    .o_Data     (o_Data),
    .o_valid    (o_valid),
    .o_substate (o_substate),
    .o_wrap     (o_wrap)
  );

  always #5 i_clock = ~i_clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Fixed directed data: memories hold 10..13, convolvers return 0x100/0x101.
  task automatic setFixedData();
    i_Data     = 8'hA5;
    i_MemData  = {13'd13, 13'd12, 13'd11, 13'd10};
    i_DataConv = {13'h101, 13'h100};
  endtask

  task automatic scrambleData();
    i_Data     = BI'($urandom);
    i_MemData  = {BD'($urandom), BD'($urandom), BD'($urandom), BD'($urandom)};
    i_DataConv = {BD'($urandom), BD'($urandom)};
  endtask

  task automatic setInputs(input logic [1:0] mode, input logic valid, input logic adv,
                           input logic clr, input logic [2:0] sel);
    i_mode      = mode;
    i_valid     = valid;
    i_advance   = adv;
    i_clearSub  = clr;
    i_memSelect = sel;
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic valid, input logic adv,
                               input logic clr, input logic [2:0] sel);
    setInputs(mode, valid, adv, clr, sel);
    @(posedge i_clock);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic        valid;
    logic        adv;
    logic        clr;
    logic [2:0]  sel;
    logic        chk_mem;
    logic [47:0] e_conv;
    logic [51:0] e_mem;
    logic [3:0]  e_we;
    logic [12:0] e_data;
    logic        e_valid;
    logic        e_sub;
    logic        e_wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [1:0] mode, input logic valid,
                              input logic adv, input logic clr, input logic [2:0] sel,
                              input logic chk_mem, input logic [47:0] e_conv,
                              input logic [51:0] e_mem, input logic [3:0] e_we,
                              input logic [12:0] e_data, input logic e_valid,
                              input logic e_sub, input logic e_wrap);
    vec_t v;
    v.name = name; v.mode = mode; v.valid = valid; v.adv = adv; v.clr = clr;
    v.sel = sel; v.chk_mem = chk_mem; v.e_conv = e_conv; v.e_mem = e_mem;
    v.e_we = e_we; v.e_data = e_data; v.e_valid = e_valid; v.e_sub = e_sub;
    v.e_wrap = e_wrap;
    return v;
  endfunction

  // Reference model: memories and taps as plain integer arrays.
  int   m_tap[N][K];
  int   m_mem[M];
  logic [M-1:0] m_we;
  int   m_data;
  logic m_valid;
  int   m_sub;
  logic m_wrap;
  bit   m_mem_known;

  function automatic void modelReset();
    for (int i = 0; i < N; i++) for (int k = 0; k < K; k++) m_tap[i][k] = 0;
    for (int j = 0; j < M; j++) m_mem[j] = 0;
    m_we = '0; m_data = 0; m_valid = 1'b0; m_sub = 0; m_wrap = 1'b0; m_mem_known = 1'b1;
  endfunction

  function automatic void modelStep();
    int mw[M];
    int cw[N];
    int base;
    for (int j = 0; j < M; j++) mw[j] = int'(i_MemData[j*BD +: BD]);
    for (int i = 0; i < N; i++) cw[i] = int'(i_DataConv[i*BD +: BD]);
    base    = (m_sub * N) % M;
    m_we    = '0;
    m_valid = i_valid && (i_mode != HOLD);
    case (i_mode)
      LOAD: begin
        for (int j = 0; j < M; j++) begin m_mem[j] = int'(i_Data); m_we[j] = i_valid; end
        for (int i = 0; i < N; i++) for (int k = 0; k < K; k++) m_tap[i][k] = 0;
        m_data = 0; m_mem_known = 1'b1;
      end
      CONV: begin
        for (int j = 0; j < M; j++) m_mem[j] = 0;
        for (int i = 0; i < N; i++) begin
          for (int k = 0; k < K; k++) m_tap[i][k] = mw[(base + i + k) % M] % 256;
          m_mem[(base + i) % M] = cw[i];
          m_we[(base + i) % M]  = i_valid;
        end
        m_data = 0; m_mem_known = 1'b1;
      end
      READ: begin
        for (int i = 0; i < N; i++) for (int k = 0; k < K; k++) m_tap[i][k] = 0;
        m_data = (int'(i_memSelect) < M) ? mw[i_memSelect] : 0;
        m_mem_known = 1'b0;
      end
      default: begin
      end
    endcase
    m_wrap = 1'b0;
    if (i_clearSub) m_sub = 0;
    else if (i_mode == CONV && i_advance) begin
      m_wrap = (m_sub == SUB - 1);
      m_sub  = (m_sub + 1) % SUB;
    end
  endfunction

  function automatic logic [N*K*BI-1:0] modelConv();
    logic [N*K*BI-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) r[(i*K+k)*BI +: BI] = BI'(m_tap[i][k]);
    return r;
  endfunction

  function automatic logic [M*BD-1:0] modelMem();
    logic [M*BD-1:0] r;
    r = '0;
    for (int j = 0; j < M; j++) r[j*BD +: BD] = BD'(m_mem[j]);
    return r;
  endfunction

  localparam logic [47:0] C0 = {8'd13, 8'd12, 8'd11, 8'd12, 8'd11, 8'd10};
  localparam logic [47:0] C1 = {8'd11, 8'd10, 8'd13, 8'd10, 8'd13, 8'd12};
  localparam logic [51:0] M0 = {13'd0, 13'd0, 13'h101, 13'h100};
  localparam logic [51:0] M1 = {13'h101, 13'h100, 13'd0, 13'd0};
  localparam logic [51:0] ML = {13'h0A5, 13'h0A5, 13'h0A5, 13'h0A5};

  initial begin
    setFixedData();
    #12;
    checkOutput("reset_conv", 64'(o_DataConv), 64'd0);
    checkOutput("reset_mem", 64'(o_MemData), 64'd0);
    checkOutput("reset_we", 64'(o_memWe), 64'd0);
    checkOutput("reset_valid", 64'(o_valid), 64'd0);
    checkOutput("reset_sub", 64'(o_substate), 64'd0);
    @(negedge i_clock);
    i_reset = 1'b1;

    vecs.push_back(mk("load",      LOAD, 1, 0, 0, 0, 1, 48'd0, ML, 4'hF, 13'd0, 1, 0, 0));
    vecs.push_back(mk("conv_s0",   CONV, 1, 0, 0, 0, 1, C0, M0, 4'h3, 13'd0, 1, 0, 0));
    vecs.push_back(mk("conv_adv0", CONV, 1, 1, 0, 0, 1, C0, M0, 4'h3, 13'd0, 1, 1, 0));
    vecs.push_back(mk("conv_s1",   CONV, 1, 0, 0, 0, 1, C1, M1, 4'hC, 13'd0, 1, 1, 0));
    vecs.push_back(mk("conv_wrap", CONV, 1, 1, 0, 0, 1, C1, M1, 4'hC, 13'd0, 1, 0, 1));
    vecs.push_back(mk("conv_post", CONV, 1, 0, 0, 0, 1, C0, M0, 4'h3, 13'd0, 1, 0, 0));
    vecs.push_back(mk("conv_adv1", CONV, 1, 1, 0, 0, 1, C0, M0, 4'h3, 13'd0, 1, 1, 0));
    vecs.push_back(mk("adv_clr",   CONV, 1, 1, 1, 0, 1, C1, M1, 4'hC, 13'd0, 1, 0, 0));
    vecs.push_back(mk("read3",     READ, 1, 1, 0, 3, 0, 48'd0, 52'd0, 4'h0, 13'd13, 1, 0, 0));
    vecs.push_back(mk("read4",     READ, 1, 0, 0, 4, 0, 48'd0, 52'd0, 4'h0, 13'd0, 1, 0, 0));
    vecs.push_back(mk("read2_nv",  READ, 0, 0, 0, 2, 0, 48'd0, 52'd0, 4'h0, 13'd12, 0, 0, 0));
    vecs.push_back(mk("conv_nv",   CONV, 0, 0, 0, 0, 1, C0, M0, 4'h0, 13'd0, 0, 0, 0));
    vecs.push_back(mk("conv_v",    CONV, 1, 0, 0, 0, 1, C0, M0, 4'h3, 13'd0, 1, 0, 0));
    vecs.push_back(mk("hold1",     HOLD, 1, 1, 0, 3, 1, C0, M0, 4'h0, 13'd0, 0, 0, 0));
    vecs.push_back(mk("hold2",     HOLD, 1, 1, 0, 3, 1, C0, M0, 4'h0, 13'd0, 0, 0, 0));
    vecs.push_back(mk("hold3",     HOLD, 1, 1, 0, 3, 1, C0, M0, 4'h0, 13'd0, 0, 0, 0));

    foreach (vecs[n]) begin
      if (vecs[n].mode == HOLD) scrambleData();
      else setFixedData();
      applyStimulus(vecs[n].mode, vecs[n].valid, vecs[n].adv, vecs[n].clr, vecs[n].sel);
      checkOutput({vecs[n].name, "_conv"}, 64'(o_DataConv), 64'(vecs[n].e_conv));
      if (vecs[n].chk_mem)
        checkOutput({vecs[n].name, "_mem"}, 64'(o_MemData), 64'(vecs[n].e_mem));
      checkOutput({vecs[n].name, "_we"}, 64'(o_memWe), 64'(vecs[n].e_we));
      checkOutput({vecs[n].name, "_data"}, 64'(o_Data), 64'(vecs[n].e_data));
      checkOutput({vecs[n].name, "_valid"}, 64'(o_valid), 64'(vecs[n].e_valid));
      checkOutput({vecs[n].name, "_sub"}, 64'(o_substate), 64'(vecs[n].e_sub));
      checkOutput({vecs[n].name, "_wrap"}, 64'(o_wrap), 64'(vecs[n].e_wrap));
    end

    // Asynchronous reset in the middle of CONV traffic.
    setFixedData();
    applyStimulus(CONV, 1, 1, 0, 0);
    checkOutput("pre_rst_sub", 64'(o_substate), 64'd1);
    i_reset = 1'b0;
    #1;
    checkOutput("rst_conv", 64'(o_DataConv), 64'd0);
    checkOutput("rst_mem", 64'(o_MemData), 64'd0);
    checkOutput("rst_we", 64'(o_memWe), 64'd0);
    checkOutput("rst_valid", 64'(o_valid), 64'd0);
    checkOutput("rst_sub", 64'(o_substate), 64'd0);
    @(posedge i_clock);
    #1;
    checkOutput("rst_held_mem", 64'(o_MemData), 64'd0);
    i_reset = 1'b1;
    applyStimulus(CONV, 0, 0, 0, 0);
    checkOutput("rel_nv_valid", 64'(o_valid), 64'd0);
    applyStimulus(CONV, 1, 0, 0, 0);
    checkOutput("rel_valid", 64'(o_valid), 64'd1);
    checkOutput("rel_we", 64'(o_memWe), 64'h3);
    checkOutput("rel_conv", 64'(o_DataConv), 64'(C0));

    // Random traffic against the reference model.
    i_reset = 1'b0;
    #2;
    i_reset = 1'b1;
    modelReset();
    for (int c = 0; c < 400; c++) begin
      scrambleData();
      setInputs(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 7) == 0), 3'($urandom));
      modelStep();
      @(posedge i_clock);
      #1;
      checkOutput("rnd_conv", 64'(o_DataConv), 64'(modelConv()));
      if (m_mem_known) checkOutput("rnd_mem", 64'(o_MemData), 64'(modelMem()));
      checkOutput("rnd_we", 64'(o_memWe), 64'(m_we));
      checkOutput("rnd_data", 64'(o_Data), 64'(m_data));
      checkOutput("rnd_valid", 64'(o_valid), 64'(m_valid));
      checkOutput("rnd_sub", 64'(o_substate), 64'(m_sub));
      checkOutput("rnd_wrap", 64'(o_wrap), 64'(m_wrap));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
